regfile_bist_ctrl: RTL and testbench
====================================

Name: regfile_bist_ctrl

Overview:
Built-in self-test controller that acts as the initiator on the 8-entry register file's write/dual-read interface. On a start pulse it writes a seeded pattern to every register through the W port, then reads all registers back through the R and S ports two words per cycle. It compares each word against the expected pattern and reports pass/fail, the mismatch count and the first failing address. It sits beside the register file and shares its address/data buses, muxed in by the datapath during test.

Parameters:
DATA_WIDTH, 16, width of W, R and S
ADDR_WIDTH, 3, register address width; NUM_REGS = 2**ADDR_WIDTH (default 8), must be even

Ports:
clk  input  1  system clock, all flops on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  begin a test run; sampled only in IDLE
seed  input  DATA_WIDTH  pattern seed, captured when start is accepted
R  input  DATA_WIDTH  register file R read data (combinational read of R_Adr)
S  input  DATA_WIDTH  register file S read data (combinational read of S_Adr)
we  output  1  write enable to register file
W_Adr  output  ADDR_WIDTH  write address
W  output  DATA_WIDTH  write data
R_Adr  output  ADDR_WIDTH  R read address
S_Adr  output  ADDR_WIDTH  S read address
busy  output  1  run in progress
done  output  1  one-cycle pulse at end of run
pass  output  1  run completed with zero mismatches
err_count  output  ADDR_WIDTH+1  number of mismatching words (0..NUM_REGS)
first_err_adr  output  ADDR_WIDTH  address of first mismatch, 0 if none

Behaviour:
- Reset is asynchronous and active-high. All outputs are registered. Reset values: we=0, W_Adr=0, W=0, R_Adr=0, S_Adr=0, busy=0, done=0, pass=0, err_count=0, first_err_adr=0. FSM goes to IDLE.
- Reset asserted mid-run: we drops immediately, the run is abandoned, and no done pulse is produced.
- Pattern: P(a) = seed_q XOR ~zero_extend(a). With seed 0, P(0)=16'hFFFF and P(7)=16'hFFF8.
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE: busy=0, we=0.
  - start=1 at a rising edge: capture seed_q, clear pass, err_count and first_err_adr, go to WRITE.
- WRITE (NUM_REGS cycles, k=0..NUM_REGS-1): we=1, W_Adr=k, W=P(k). The register file captures each word at the edge ending cycle k. After the last cycle go to READ.
- READ (NUM_REGS/2 cycles, j=0..NUM_REGS/2-1): we=0, R_Adr=j, S_Adr=j+NUM_REGS/2.
  - At the edge ending the cycle, compare R against P(j) and S against P(j+NUM_REGS/2).
  - Each mismatch increments err_count.
  - The first mismatch of the run loads first_err_adr. Within one cycle, the R-port address takes priority over the S-port address.
  - After the last cycle go to DONE.
- DONE (1 cycle): done=1, busy=0, pass=(err_count==0). Next state IDLE.
- Results (pass, err_count, first_err_adr) hold until the next accepted start.
- busy is 1 for exactly NUM_REGS + NUM_REGS/2 cycles (12 by default), starting the cycle after start is accepted. done is high the following cycle.
- start outside IDLE is ignored, including during DONE. Start held high continuously re-triggers from IDLE, one run per IDLE visit.
- Address counters do not wrap mid-phase. The phase ends exactly on the last address.
- After a run, W_Adr, R_Adr and S_Adr return to 0 in IDLE, and W returns to 0.
- err_count saturates naturally; its maximum of NUM_REGS fits in ADDR_WIDTH+1 bits.

Test Plan:
- Fault-free run: reset pulse, then start with seed=0 against a behavioural register file. Required: writes FFFF, FFFE, ... FFF8 to addresses 0..7; reads pair (0,4)..(3,7); busy for 12 cycles; done on cycle 13; pass=1; err_count=0; first_err_adr=0.
- Seed check: seed=16'h00FF. Required: W at address 0 is FF00 and at address 7 is FF07; pass=1.
- Single fault: register 5 bit 0 stuck at 1, seed=0. Required: err_count=1, first_err_adr=5, pass=0.
- Same-cycle priority: faults in registers 1 and 5. Required: err_count=2, first_err_adr=1, because R-port priority applies in read cycle 1.
- Start during busy: pulse start at WRITE cycle 4 and again in DONE. Required: exactly one run and one done pulse; results unchanged by the extra pulses.
- Mid-run reset: assert reset during WRITE cycle 3. Required: we=0 and all outputs at reset values within the same cycle; no done pulse. A fresh start afterwards completes a full run with pass=1.

Source files
------------

// File: rtl/regfile_bist_ctrl_if.sv
// Write/dual-read bus between the BIST controller (master) and the register file (slave).
// The W port writes, and the R and S ports are two independent combinational read ports.
interface regfile_bist_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] W_Adr;
  logic [DATA_WIDTH-1:0] W;
  logic [ADDR_WIDTH-1:0] R_Adr;
  logic [ADDR_WIDTH-1:0] S_Adr;
  logic [DATA_WIDTH-1:0] R;
  logic [DATA_WIDTH-1:0] S;

  modport master (
    output we, W_Adr, W, R_Adr, S_Adr,
    input  R, S
  );

  modport slave (
    input  we, W_Adr, W, R_Adr, S_Adr,
    output R, S
  );
endinterface

// File: rtl/regfile_bist_ctrl.sv
// Register-file BIST: writes a seeded pattern to every entry, then reads it back two words
// per cycle and reports the pass flag, the mismatch count and the first failing address.
module regfile_bist_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  regfile_bist_ctrl_if.master   rf,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH:0]   err_count,
  output logic [ADDR_WIDTH-1:0] first_err_adr
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int CW       = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_W = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] HALF   = ADDR_WIDTH'(NUM_REGS / 2);
  localparam logic [ADDR_WIDTH-1:0] LAST_R = ADDR_WIDTH'(NUM_REGS / 2 - 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0] r_seed;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_w_adr;
  logic [DATA_WIDTH-1:0] r_w;
  logic [ADDR_WIDTH-1:0] r_r_adr;
  logic [ADDR_WIDTH-1:0] r_s_adr;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [CW-1:0]         r_err_count;
  logic [ADDR_WIDTH-1:0] r_first_err_adr;

  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] w_cnt_next;
  logic [DATA_WIDTH-1:0] w_seed_next;
  logic                  w_we_next;
  logic [ADDR_WIDTH-1:0] w_w_adr_next;
  logic [DATA_WIDTH-1:0] w_w_next;
  logic [ADDR_WIDTH-1:0] w_r_adr_next;
  logic [ADDR_WIDTH-1:0] w_s_adr_next;
  logic                  w_busy_next;
  logic                  w_done_next;
  logic                  w_pass_next;
  logic [CW-1:0]         w_err_next;
  logic [ADDR_WIDTH-1:0] w_first_next;

  logic [ADDR_WIDTH-1:0] w_cnt_inc;
  logic [ADDR_WIDTH-1:0] w_rd_adr  [2];
  logic [DATA_WIDTH-1:0] w_rd_data [2];
  logic [1:0]            w_mis;
  logic [CW-1:0]         w_err_sum;

  // P(a) = seed XOR NOT(zero-extended a)
  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [DATA_WIDTH-1:0] s,
                                                    input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] ext;
    ext = '0;
    ext[ADDR_WIDTH-1:0] = a;
    return s ^ ~ext;
  endfunction

  assign w_cnt_inc    = r_cnt + ADDR_WIDTH'(1);
  assign w_rd_adr[0]  = r_cnt;
  assign w_rd_adr[1]  = r_cnt + HALF;
  assign w_rd_data[0] = rf.R;
  assign w_rd_data[1] = rf.S;

  // Port 0 is R (lower half), port 1 is S (upper half); both are checked every read cycle.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cmp
      assign w_mis[gi] = (w_rd_data[gi] != pattern(r_seed, w_rd_adr[gi]));
    end
  endgenerate

  assign w_err_sum = r_err_count + CW'(w_mis[0]) + CW'(w_mis[1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_seed          <= '0;
      r_we            <= 1'b0;
      r_w_adr         <= '0;
      r_w             <= '0;
      r_r_adr         <= '0;
      r_s_adr         <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_err_count     <= '0;
      r_first_err_adr <= '0;
    end else begin
      r_state         <= w_state_next;
      r_cnt           <= w_cnt_next;
      r_seed          <= w_seed_next;
      r_we            <= w_we_next;
      r_w_adr         <= w_w_adr_next;
      r_w             <= w_w_next;
      r_r_adr         <= w_r_adr_next;
      r_s_adr         <= w_s_adr_next;
      r_busy          <= w_busy_next;
      r_done          <= w_done_next;
      r_pass          <= w_pass_next;
      r_err_count     <= w_err_next;
      r_first_err_adr <= w_first_next;
    end
  end

  // Every output register is loaded with the value it must show in the next state's cycle.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_seed_next  = r_seed;
    w_we_next    = 1'b0;
    w_w_adr_next = '0;
    w_w_next     = '0;
    w_r_adr_next = '0;
    w_s_adr_next = '0;
    w_busy_next  = 1'b0;
    w_done_next  = 1'b0;
    w_pass_next  = r_pass;
    w_err_next   = r_err_count;
    w_first_next = r_first_err_adr;

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = WRITE;
          w_cnt_next   = '0;
          w_seed_next  = seed;
          w_pass_next  = 1'b0;
          w_err_next   = '0;
          w_first_next = '0;
          w_busy_next  = 1'b1;
          w_we_next    = 1'b1;
          w_w_next     = pattern(seed, '0);
        end
      end
      WRITE: begin
        w_busy_next = 1'b1;
        if (r_cnt == LAST_W) begin
          w_state_next = READ;
          w_cnt_next   = '0;
          w_s_adr_next = HALF;
        end else begin
          w_cnt_next   = w_cnt_inc;
          w_we_next    = 1'b1;
          w_w_adr_next = w_cnt_inc;
          w_w_next     = pattern(r_seed, w_cnt_inc);
        end
      end
      READ: begin
        w_err_next = w_err_sum;
        // A zero count before this cycle means no earlier mismatch; R wins a same-cycle tie.
        if ((r_err_count == '0) && (w_mis != 2'b00)) begin
          w_first_next = w_mis[0] ? w_rd_adr[0] : w_rd_adr[1];
        end
        if (r_cnt == LAST_R) begin
          w_state_next = DONE;
          w_cnt_next   = '0;
          w_done_next  = 1'b1;
          w_pass_next  = (w_err_sum == '0);
        end else begin
          w_cnt_next   = w_cnt_inc;
          w_busy_next  = 1'b1;
          w_r_adr_next = w_cnt_inc;
          w_s_adr_next = w_cnt_inc + HALF;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign rf.we         = r_we;
  assign rf.W_Adr      = r_w_adr;
  assign rf.W          = r_w;
  assign rf.R_Adr      = r_r_adr;
  assign rf.S_Adr      = r_s_adr;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_count     = r_err_count;
  assign first_err_adr = r_first_err_adr;

endmodule

// File: tb/tb_regfile_bist_ctrl.sv
// Bench for regfile_bist_ctrl: behavioural register file with stuck-at-1 fault injection,
// a bus scoreboard, table-driven runs and hand-written start/reset corner sequences.
module tb_regfile_bist_ctrl;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic [DW-1:0] seed;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_adr;

  regfile_bist_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) rf ();

  regfile_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .seed          (seed),
    .rf            (rf),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_adr (first_err_adr)
  );

  // Behavioural register file; selected entries have one bit stuck at 1 on both read ports.
  logic [DW-1:0] mem [NR];
  logic [7:0]    stuck_regs;
  logic [3:0]    stuck_bit;

  function automatic logic [DW-1:0] fault_mask(input logic [7:0] regs, input logic [3:0] b,
                                               input logic [AW-1:0] a);
    logic [DW-1:0] m;
    m = '0;
    if (regs[a]) m[b] = 1'b1;
    return m;
  endfunction

  always @(posedge clk) if (rf.we) mem[rf.W_Adr] <= rf.W;

  always_comb begin
    rf.R = mem[rf.R_Adr] | fault_mask(stuck_regs, stuck_bit, rf.R_Adr);
    rf.S = mem[rf.S_Adr] | fault_mask(stuck_regs, stuck_bit, rf.S_Adr);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_pat(input logic [DW-1:0] sd, input int a);
    return sd ^ (16'hFFFF - 16'(a));
  endfunction

  // Scoreboard: expected bus transactions queued at start, popped as the DUT drives the bus.
  typedef struct packed { logic [AW-1:0] adr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { logic [AW-1:0] r;   logic [AW-1:0] s;    } rd_t;
  wr_t           wq [$];
  rd_t           rq [$];
  wr_t           mon_w;
  rd_t           mon_r;
  logic [DW-1:0] cap_w [NR];
  int            done_pulses = 0;

  task automatic push_expect(input logic [DW-1:0] sd);
    for (int k = 0; k < NR; k++) wq.push_back('{adr: AW'(k), data: exp_pat(sd, k)});
    for (int j = 0; j < NR / 2; j++) rq.push_back('{r: AW'(j), s: AW'(j + NR / 2)});
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (rf.we) begin
        if (wq.size() == 0) chk("sb_write_unexpected", 32'(rf.W_Adr), 32'hFFFF);
        else begin
          mon_w = wq.pop_front();
          chk("sb_w_adr", 32'(rf.W_Adr), 32'(mon_w.adr));
          chk("sb_w_data", 32'(rf.W), 32'(mon_w.data));
        end
        cap_w[rf.W_Adr] = rf.W;
      end else if (busy) begin
        if (rq.size() == 0) chk("sb_read_unexpected", 32'(rf.R_Adr), 32'hFFFF);
        else begin
          mon_r = rq.pop_front();
          chk("sb_r_adr", 32'(rf.R_Adr), 32'(mon_r.r));
          chk("sb_s_adr", 32'(rf.S_Adr), 32'(mon_r.s));
        end
      end
      if (done) done_pulses++;
    end
  end

  typedef struct {
    logic [15:0] seed;
    logic [7:0]  regs;
    logic [3:0]  bitn;
    logic [15:0] w0;
    logic [15:0] w7;
    int          err;
    int          first;
    bit          pass;
  } vec_t;
  vec_t vt [8];

  task automatic check_reset_vals(input string tag);
    chk({tag, "_we"}, 32'(rf.we), 0);
    chk({tag, "_w_adr"}, 32'(rf.W_Adr), 0);
    chk({tag, "_w"}, 32'(rf.W), 0);
    chk({tag, "_r_adr"}, 32'(rf.R_Adr), 0);
    chk({tag, "_s_adr"}, 32'(rf.S_Adr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_err_count"}, 32'(err_count), 0);
    chk({tag, "_first_err"}, 32'(first_err_adr), 0);
  endtask

  task automatic run_one(input logic [DW-1:0] sd, input int extra_w, input bit extra_d,
                         output int bc, output int da);
    bc = 0;
    da = -1;
    @(negedge clk);
    seed  = sd;
    start = 1'b1;
    for (int c = 0; c < 40 && da < 0; c++) begin
      @(negedge clk);
      if (c == 0) seed = ~sd;
      if (busy) bc++;
      if (done) da = c;
      start = (c == extra_w) || (extra_d && done);
    end
    @(negedge clk);
    start = 1'b0;
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_we", 32'(rf.we), 0);
    chk("idle_w_adr", 32'(rf.W_Adr), 0);
    chk("idle_w", 32'(rf.W), 0);
    chk("idle_r_adr", 32'(rf.R_Adr), 0);
    chk("idle_s_adr", 32'(rf.S_Adr), 0);
  endtask

  task automatic do_row(input int i, input int extra_w, input bit extra_d);
    int bc, da, dp0;
    stuck_regs = vt[i].regs;
    stuck_bit  = vt[i].bitn;
    dp0        = done_pulses;
    for (int k = 0; k < NR; k++) cap_w[k] = 16'hDEAD;
    push_expect(vt[i].seed);
    run_one(vt[i].seed, extra_w, extra_d, bc, da);
    chk("busy_cycles", 32'(bc), 12);
    chk("done_cycle", 32'(da), 12);
    chk("pass", 32'(pass), 32'(vt[i].pass));
    chk("err_count", 32'(err_count), 32'(vt[i].err));
    chk("first_err_adr", 32'(first_err_adr), 32'(vt[i].first));
    chk("w_at_adr0", 32'(cap_w[0]), 32'(vt[i].w0));
    chk("w_at_adr7", 32'(cap_w[7]), 32'(vt[i].w7));
    chk("sb_writes_left", 32'(wq.size()), 0);
    chk("sb_reads_left", 32'(rq.size()), 0);
    chk("done_pulses", 32'(done_pulses - dp0), 1);
    $display("run row=%0d seed=%h err=%0d first=%0d pass=%0b busy=%0d done_at=%0d",
             i, vt[i].seed, err_count, first_err_adr, pass, bc, da);
  endtask

  initial begin
    int dp0, bc;
    reset      = 1'b1;
    start      = 1'b0;
    seed       = '0;
    stuck_regs = '0;
    stuck_bit  = '0;
    for (int k = 0; k < NR; k++) mem[k] = '0;

    //        seed      regs          bit  w0        w7        err first pass
    vt[0] = '{16'h0000, 8'b0000_0000, 4'd0, 16'hFFFF, 16'hFFF8, 0, 0, 1'b1};
    vt[1] = '{16'h00FF, 8'b0000_0000, 4'd0, 16'hFF00, 16'hFF07, 0, 0, 1'b1};
    vt[2] = '{16'h0000, 8'b0010_0000, 4'd0, 16'hFFFF, 16'hFFF8, 1, 5, 1'b0};
    vt[3] = '{16'h0000, 8'b0010_0010, 4'd0, 16'hFFFF, 16'hFFF8, 2, 1, 1'b0};
    vt[4] = '{16'h0000, 8'b0001_0000, 4'd0, 16'hFFFF, 16'hFFF8, 0, 0, 1'b1};
    vt[5] = '{16'hFFFF, 8'b1111_1111, 4'd15, 16'h0000, 16'h0007, 8, 0, 1'b0};
    vt[6] = '{16'hFFFF, 8'b0001_0100, 4'd0, 16'h0000, 16'h0007, 2, 4, 1'b0};
    vt[7] = '{16'h1234, 8'b1000_0000, 4'd0, 16'hEDCB, 16'hEDCC, 1, 7, 1'b0};

    repeat (3) @(negedge clk);
    check_reset_vals("rst_held");
    reset = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_idle");

    for (int i = 0; i < 8; i++) do_row(i, -1, 1'b0);

    // Extra start pulses in WRITE cycle 4 and in DONE must be ignored.
    do_row(3, 4, 1'b1);
    dp0 = done_pulses;
    bc  = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy) bc++;
    end
    chk("ignored_start_busy", 32'(bc), 0);
    chk("ignored_start_done", 32'(done_pulses - dp0), 0);
    chk("hold_err_count", 32'(err_count), 2);
    chk("hold_first_err", 32'(first_err_adr), 1);
    chk("hold_pass", 32'(pass), 0);

    // Reset in WRITE cycle 3 abandons the run immediately.
    stuck_regs = '0;
    dp0        = done_pulses;
    push_expect(16'h0000);
    @(negedge clk);
    seed  = 16'h0000;
    start = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_reset_we", 32'(rf.we), 1);
    reset = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    wq.delete();
    rq.delete();
    @(negedge clk);
    reset = 1'b0;
    bc    = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) bc++;
    end
    chk("post_rst_busy", 32'(bc), 0);
    chk("post_rst_no_done", 32'(done_pulses - dp0), 0);
    $display("mid-run reset applied in WRITE cycle 3, done_pulses=%0d", done_pulses - dp0);

    do_row(0, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
